// File: rtl/bp_stall_counter_bank.sv
// Stall-attribution counter bank. It keeps one live counter per stall reason,
// plus a cycles counter and an instret counter. An atomic snapshot copies them
// into a shadow set, and the host reads the shadow set over a valid/ready port.
module bp_stall_counter_bank #(
  parameter int num_reasons_p   = 24,
  parameter int reason_width_p  = 5,
  parameter int width_p         = 32,
  parameter int saturate_p      = 0,
  parameter int clear_on_snap_p = 0,
  localparam int addr_width_lp  = $clog2(num_reasons_p + 2)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_i,
  input  logic                      count_en_i,
  input  logic                      instret_i,
  input  logic [reason_width_p-1:0] stall_reason_i,
  input  logic                      snapshot_i,
  input  logic                      req_v_i,
  input  logic [addr_width_lp-1:0]  req_addr_i,
  output logic                      req_ready_o,
  output logic                      resp_v_o,
  output logic [width_p-1:0]        resp_data_o,
  output logic                      resp_ovf_o,
  input  logic                      resp_ready_i
);

  localparam int num_ctr_lp = num_reasons_p + 2;
  localparam int cyc_idx_lp = num_reasons_p;
  localparam int ins_idx_lp = num_reasons_p + 1;

  logic [width_p-1:0]       live_cnt   [num_ctr_lp];
  logic [num_ctr_lp-1:0]    live_ovf;
  logic [width_p-1:0]       shadow_cnt [num_ctr_lp];
  logic [num_ctr_lp-1:0]    shadow_ovf;
  logic [width_p-1:0]       nxt_cnt    [num_ctr_lp];
  logic [num_ctr_lp-1:0]    nxt_ovf;
  logic [num_ctr_lp-1:0]    inc;
  logic [num_reasons_p-1:0] reason_hit;
  logic                     restart;
  logic [width_p-1:0]       rd_data;
  logic                     rd_ovf;
  logic                     accept;

  assign restart = snapshot_i & (clear_on_snap_p != 0);

  // Decode the stall reason. Codes that map to no reason fall into the catch-all counter.
  always_comb begin
    reason_hit = '0;
    for (int unsigned i = 0; i < num_reasons_p; i++) begin
      reason_hit[i] = (stall_reason_i == reason_width_p'(i));
    end
    if (~|reason_hit) reason_hit[num_reasons_p-1] = 1'b1;
  end

  // Build the per-counter increment enables. No counting happens while frozen.
  always_comb begin
    inc = '0;
    if (count_en_i & ~freeze_i) begin
      inc[cyc_idx_lp] = 1'b1;
      inc[ins_idx_lp] = instret_i;
      if (!instret_i) inc[num_reasons_p-1:0] = reason_hit;
    end
  end

  // Compute the next live values. A clearing snapshot restarts each counter from 0 before its increment.
  always_comb begin
    for (int unsigned i = 0; i < num_ctr_lp; i++) begin
      nxt_cnt[i] = restart ? '0 : live_cnt[i];
      nxt_ovf[i] = restart ? 1'b0 : live_ovf[i];
      if (inc[i]) begin
        if (&nxt_cnt[i]) begin
          nxt_ovf[i] = 1'b1;
          if (saturate_p == 0) nxt_cnt[i] = '0;
        end else begin
          nxt_cnt[i] = nxt_cnt[i] + width_p'(1);
        end
      end
    end
  end

  // Live counter and overflow registers. Freeze clears them.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || freeze_i) begin
      for (int unsigned i = 0; i < num_ctr_lp; i++) live_cnt[i] <= '0;
      live_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < num_ctr_lp; i++) live_cnt[i] <= nxt_cnt[i];
      live_ovf <= nxt_ovf;
    end
  end

  // Shadow set. It captures the live values as they stood before this cycle's update.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < num_ctr_lp; i++) shadow_cnt[i] <= '0;
      shadow_ovf <= '0;
    end else if (snapshot_i) begin
      for (int unsigned i = 0; i < num_ctr_lp; i++) shadow_cnt[i] <= live_cnt[i];
      shadow_ovf <= live_ovf;
    end
  end

  // Shadow read mux. An address with no matching counter reads as zero.
  always_comb begin
    rd_data = '0;
    rd_ovf  = 1'b0;
    for (int unsigned i = 0; i < num_ctr_lp; i++) begin
      if (req_addr_i == addr_width_lp'(i)) begin
        rd_data = shadow_cnt[i];
        rd_ovf  = shadow_ovf[i];
      end
    end
  end

  assign req_ready_o = ~resp_v_o | resp_ready_i;
  assign accept      = req_v_i & req_ready_o;

  // Single-entry response register. It holds its fields while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_v_o    <= 1'b0;
      resp_data_o <= '0;
      resp_ovf_o  <= 1'b0;
    end else if (accept) begin
      resp_v_o    <= 1'b1;
      resp_data_o <= rd_data;
      resp_ovf_o  <= rd_ovf;
    end else if (resp_ready_i) begin
      resp_v_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_stall_counter_bank.sv
// Bench for bp_stall_counter_bank. Two 8-bit instances share one stimulus stream.
// Instance u_wrap wraps and keeps its counts on snapshot.
// Instance u_sat saturates and clears its live counts on snapshot.
module tb_bp_stall_counter_bank;

  logic       clk;
  logic       reset_n;
  logic       freeze;
  logic       count_en;
  logic       instret;
  logic [4:0] stall_reason;
  logic       snapshot;
  logic       req_v;
  logic [4:0] req_addr;
  logic       resp_ready;

  logic       req_ready_a, resp_v_a, resp_ovf_a;
  logic [7:0] resp_data_a;
  logic       req_ready_b, resp_v_b, resp_ovf_b;
  logic [7:0] resp_data_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] da;
    logic       oa;
    logic [7:0] db;
    logic       ob;
  } exp_t;

  exp_t sb_q[$];

  bp_stall_counter_bank #(
    .num_reasons_p(24), .reason_width_p(5), .width_p(8),
    .saturate_p(0), .clear_on_snap_p(0)
  ) u_wrap (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .count_en_i(count_en),
    .instret_i(instret), .stall_reason_i(stall_reason), .snapshot_i(snapshot),
    .req_v_i(req_v), .req_addr_i(req_addr), .req_ready_o(req_ready_a),
    .resp_v_o(resp_v_a), .resp_data_o(resp_data_a), .resp_ovf_o(resp_ovf_a),
    .resp_ready_i(resp_ready)
  );

  bp_stall_counter_bank #(
    .num_reasons_p(24), .reason_width_p(5), .width_p(8),
    .saturate_p(1), .clear_on_snap_p(1)
  ) u_sat (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .count_en_i(count_en),
    .instret_i(instret), .stall_reason_i(stall_reason), .snapshot_i(snapshot),
    .req_v_i(req_v), .req_addr_i(req_addr), .req_ready_o(req_ready_b),
    .resp_v_o(resp_v_b), .resp_data_o(resp_data_b), .resp_ovf_o(resp_ovf_b),
    .resp_ready_i(resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop and compare on the falling edge, whenever a response is consumed.
  always @(negedge clk) begin
    if (reset_n && resp_v_a && resp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_resp", 32'(sb_q.size()), 32'(1));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("rd%0d_data_a", e.addr), 32'(resp_data_a), 32'(e.da));
        check($sformatf("rd%0d_ovf_a", e.addr),  32'(resp_ovf_a),  32'(e.oa));
        check($sformatf("rd%0d_v_b", e.addr),    32'(resp_v_b),    32'(1));
        check($sformatf("rd%0d_data_b", e.addr), 32'(resp_data_b), 32'(e.db));
        check($sformatf("rd%0d_ovf_b", e.addr),  32'(resp_ovf_b),  32'(e.ob));
      end
    end
  end

  task automatic rd(input int unsigned addr, input int unsigned da, input int unsigned oa,
                    input int unsigned db, input int unsigned ob);
    int unsigned n;
    exp_t e;
    req_v    = 1'b1;
    req_addr = 5'(addr);
    #1;
    n = 0;
    while (!(req_ready_a && req_ready_b) && n < 50) begin
      step();
      #1;
      n++;
    end
    if (n >= 50) check("rd_accept_timeout", 32'(req_ready_a), 32'(1));
    e.addr = 5'(addr);
    e.da = 8'(da);
    e.oa = oa[0];
    e.db = 8'(db);
    e.ob = ob[0];
    sb_q.push_back(e);
    step();
    req_v = 1'b0;
    check("rd_latency_v", 32'(resp_v_a), 32'(1));
  endtask

  task automatic drain();
    int unsigned n;
    req_v = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_left", 32'(sb_q.size()), 32'(0));
    check("idle_v_a", 32'(resp_v_a), 32'(0));
  endtask

  task automatic run(input int unsigned n, input logic ins, input int unsigned reason);
    count_en     = 1'b1;
    instret      = ins;
    stall_reason = 5'(reason);
    for (int unsigned i = 0; i < n; i++) step();
    count_en = 1'b0;
    instret  = 1'b0;
  endtask

  task automatic snap();
    snapshot = 1'b1;
    step();
    snapshot = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d exp=%0d", $time, 200000);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; freeze = 1'b0; count_en = 1'b0; instret = 1'b0;
    stall_reason = '0; snapshot = 1'b0; req_v = 1'b0; req_addr = '0; resp_ready = 1'b1;
    step(); step(); step();
    reset_n = 1'b1;

    // Reset state
    check("rst_v_a", 32'(resp_v_a), 32'(0));
    check("rst_v_b", 32'(resp_v_b), 32'(0));
    check("rst_rdy_a", 32'(req_ready_a), 32'(1));
    check("rst_rdy_b", 32'(req_ready_b), 32'(1));
    check("rst_data_a", 32'(resp_data_a), 32'(0));

    // Attribution
    run(4, 1'b1, 0);
    run(3, 1'b0, 2);
    run(3, 1'b0, 30);
    snap();
    rd(2, 3, 0, 3, 0);
    rd(23, 3, 0, 3, 0);
    rd(24, 10, 0, 10, 0);
    rd(25, 4, 0, 4, 0);
    rd(0, 0, 0, 0, 0);
    rd(26, 0, 0, 0, 0);
    drain();

    // Overflow: 300 increments wrap to 44 in one instance and saturate at 255 in the other
    do_reset();
    run(300, 1'b0, 5);
    snap();
    rd(5, 44, 1, 255, 1);
    rd(24, 44, 1, 255, 1);
    rd(4, 0, 0, 0, 0);
    drain();
    freeze   = 1'b1;
    count_en = 1'b1;
    step();
    freeze   = 1'b0;
    count_en = 1'b0;
    snap();
    rd(5, 0, 0, 0, 0);
    rd(24, 0, 0, 0, 0);
    drain();

    // Snapshot atomicity, including a read in the snapshot cycle
    do_reset();
    run(7, 1'b0, 1);
    snapshot = 1'b1;
    run(1, 1'b0, 1);
    snapshot = 1'b0;
    run(2, 1'b0, 1);
    rd(1, 7, 0, 7, 0);
    drain();
    snapshot = 1'b1;
    rd(1, 7, 0, 7, 0);
    snapshot = 1'b0;
    rd(1, 10, 0, 3, 0);
    rd(24, 10, 0, 3, 0);
    drain();

    // Read handshake with a stalled consumer
    resp_ready = 1'b0;
    rd(1, 10, 0, 3, 0);
    req_v    = 1'b1;
    req_addr = 5'd24;
    #1;
    check("stall_rdy_a", 32'(req_ready_a), 32'(0));
    check("stall_rdy_b", 32'(req_ready_b), 32'(0));
    step();
    check("stall_data_a0", 32'(resp_data_a), 32'(10));
    check("stall_data_b0", 32'(resp_data_b), 32'(3));
    count_en = 1'b1;
    stall_reason = 5'd1;
    snapshot = 1'b1;
    step();
    count_en = 1'b0;
    snapshot = 1'b0;
    step();
    check("stall_v_a", 32'(resp_v_a), 32'(1));
    check("stall_data_a1", 32'(resp_data_a), 32'(10));
    check("stall_data_b1", 32'(resp_data_b), 32'(3));
    check("stall_rdy_a1", 32'(req_ready_a), 32'(0));
    resp_ready = 1'b1;
    rd(24, 10, 0, 0, 0);
    rd(1, 10, 0, 0, 0);
    rd(25, 0, 0, 0, 0);
    rd(0, 0, 0, 0, 0);
    rd(31, 0, 0, 0, 0);
    drain();

    // Reset while a response is pending and the counters are non-zero
    run(5, 1'b1, 0);
    snap();
    resp_ready = 1'b0;
    req_v    = 1'b1;
    req_addr = 5'd24;
    step();
    req_v = 1'b0;
    check("pre_rst_v_a", 32'(resp_v_a), 32'(1));
    reset_n = 1'b0;
    step();
    check("mid_rst_v_a", 32'(resp_v_a), 32'(0));
    check("mid_rst_v_b", 32'(resp_v_b), 32'(0));
    check("mid_rst_rdy_a", 32'(req_ready_a), 32'(1));
    check("mid_rst_data_a", 32'(resp_data_a), 32'(0));
    reset_n = 1'b1;
    resp_ready = 1'b1;
    sb_q.delete();
    for (int unsigned a = 0; a < 26; a++) rd(a, 0, 0, 0, 0);
    drain();
    snap();
    rd(24, 0, 0, 0, 0);
    rd(25, 0, 0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_stall_counter_bank.md
# bp_stall_counter_bank

Parametrised stall-attribution counter bank for the BlackParrot core profiling path. It takes a per-cycle stall-reason code and commit indication, and keeps one counter per reason plus total-cycle and retired-instruction counters. Each counter has a configurable wrap or saturate mode and a sticky overflow flag. An atomic snapshot copies every counter into shadow registers. The host reads the shadow set over a valid/ready request/response port, so the read path never sees a live, moving value.

## Interface
Parameters:
- num_reasons_p, 24: number of stall-reason counters. Index num_reasons_p-1 is the catch-all "unknown" counter.
- reason_width_p, 5: width of the stall-reason code. Must satisfy 2^reason_width_p >= num_reasons_p.
- width_p, 32: width of each counter.
- saturate_p, 0: 1 = counters saturate at 2^width_p-1; 0 = counters wrap to 0.
- clear_on_snap_p, 0: 1 = live counters restart from 0 on snapshot.
- addr_width_lp (local), `$clog2(num_reasons_p+2)`: read-address width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, synchronous, active-low.
- freeze_i  in  1  clears live counters and overflow flags; suppresses counting.
- count_en_i  in  1  profiling enable for this cycle.
- instret_i  in  1  an instruction committed this cycle.
- stall_reason_i  in  reason_width_p  attributed stall reason; meaningful only when instret_i=0.
- snapshot_i  in  1  copy live counters and overflow flags into the shadow set.
- req_v_i  in  1  read request valid.
- req_addr_i  in  addr_width_lp  shadow index. 0..num_reasons_p-1 are the reasons, num_reasons_p is cycles, num_reasons_p+1 is instret.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- resp_v_o  out  1  response valid.
- resp_data_o  out  width_p  shadow counter value.
- resp_ovf_o  out  1  shadow overflow flag for that index.
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i.

## Operation
- Live set: num_reasons_p+2 counters, each with a sticky overflow bit. The shadow set has the same shape.
- The increment conditions are evaluated each cycle with reset_n_i=1 and freeze_i=0:
  - cycles counter: increments when count_en_i=1.
  - instret counter: increments when count_en_i & instret_i.
  - reason counter[r]: increments when count_en_i & ~instret_i, where r = stall_reason_i if stall_reason_i < num_reasons_p, else r = num_reasons_p-1.
  - At most one reason counter increments per cycle.
- Overflow handling, when an increment hits a counter at 2^width_p-1:
  - saturate_p=1: counter holds at max; overflow bit set.
  - saturate_p=0: counter becomes 0; overflow bit set.
  - The overflow bit stays set until freeze_i or reset.
- freeze_i=1: all live counters and overflow bits become 0 next cycle and no increments occur. The shadow set is untouched.
- snapshot_i=1: the shadow set captures the live register values *before* this cycle's update.
  - If clear_on_snap_p=1, each live counter becomes its this-cycle increment (0 or 1) and each live overflow bit is cleared.
  - If clear_on_snap_p=0, live counters update normally.
- snapshot_i and freeze_i in the same cycle: shadow captures the pre-clear values; live set is cleared.
- Read port:
  - A single-entry response register.
  - req_ready_o = ~resp_v_o | resp_ready_i.
  - On accept, resp_data_o and resp_ovf_o load shadow[req_addr_i]. An out-of-range address returns data 0 and ovf 0.
  - Response fields hold stable while resp_v_o=1 and resp_ready_i=0, even if a snapshot occurs meanwhile.
  - Back-to-back accept with consume gives one response per cycle.

## Timing
- Reset (reset_n_i=0 at a clock edge): all live and shadow counters, overflow bits, resp_v_o, resp_data_o and resp_ovf_o become 0.
  - req_ready_o = 1 combinationally once resp_v_o = 0.
  - Reset mid-transaction drops any pending response.
- Live counters update one cycle after the qualifying inputs.
- Snapshot: shadow is valid in the cycle after snapshot_i.
  - A read accepted in that same snapshot cycle returns the *old* shadow value.
- Read latency: resp_v_o rises the cycle after request accept.
- resp_v_o falls the cycle after consume, unless a new request is accepted in the consume cycle.
- No combinational path from count or snapshot inputs to any output. req_ready_o depends only on resp_v_o and resp_ready_i.

## Test plan
- Attribution:
  - Stimulus: reset; count_en_i=1 for 10 cycles — 4 with instret_i=1, 3 with reason 2, 3 with reason 30 (out of range); then snapshot; read indices 2, 23, 24, 25.
  - Required: 3, 3, 10, 4; all ovf=0.
- Saturate (width_p=8, saturate_p=1):
  - Stimulus: 300 cycles of reason 5; snapshot; read 5.
  - Required: data 255, ovf 1.
- Wrap (saturate_p=0, width_p=8):
  - Stimulus: same as the saturate scenario.
  - Required: data 44, ovf 1. After freeze_i, snapshot, read 5: data 0, ovf 0.
- Snapshot atomicity (clear_on_snap_p=1):
  - Stimulus: 7 cycles of reason 1; snapshot_i asserted with reason 1 still applied; 2 more cycles; snapshot; read 1.
  - Required: first read (taken before the second snapshot) = 7; second read = 3.
- Read handshake:
  - Stimulus: hold resp_ready_i=0 with a response pending; issue a snapshot; then raise resp_ready_i; issue back-to-back requests.
  - Required: req_ready_o=0 and data stable while stalled; one response per cycle once resp_ready_i=1.
- Reset mid-operation:
  - Stimulus: assert reset_n_i=0 with resp_v_o=1 and counters non-zero.
  - Required: next cycle resp_v_o=0 and every read returns 0.
